// File: rtl/npc_multicycle_sequencer.sv
// rtl/npc_multicycle_sequencer.sv - multi-cycle fetch/execute/load-store/writeback sequencer for the NPC core
module npc_multicycle_sequencer #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_resp_valid,
  output logic             ir_we,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_wen,
  input  logic             dec_halt,
  output logic             lsu_req_valid,
  output logic             lsu_wr,
  input  logic             lsu_req_ready,
  input  logic             lsu_resp_valid,
  output logic             reg_we,
  output logic             pc_we,
  output logic             halted,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF_REQ  = 3'd0,
    S_IF_WAIT = 3'd1,
    S_EX      = 3'd2,
    S_LS_REQ  = 3'd3,
    S_LS_WAIT = 3'd4,
    S_WB      = 3'd5,
    S_HALTED  = 3'd6,
    S_BAD     = 3'd7
  } state_t;

  // Counter must reach TIMEOUT itself: after a last-cycle handshake it steps once more into the WAIT state.
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            cur_state;
  state_t            nxt_state;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [CNT_W-1:0]  instret_q;
  logic              err_q;
  logic              in_bus_phase;
  logic              tmo_hit;
  logic              set_err;
  logic              retire;

  assign in_bus_phase = (cur_state == S_IF_REQ) || (cur_state == S_IF_WAIT) ||
                        (cur_state == S_LS_REQ) || (cur_state == S_LS_WAIT);
  assign tmo_hit      = (TIMEOUT != 0) && (tmo_cnt >= TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IF_REQ;
      tmo_cnt   <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      // Outside REQ/WAIT the counter idles at zero, so every REQ entry starts a fresh count.
      if (in_bus_phase)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      else
        tmo_cnt <= '0;
      if (retire)
        instret_q <= instret_q + CNT_W'(1);
      if (set_err)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    ifu_req_valid = 1'b0;
    ir_we         = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_wr        = 1'b0;
    reg_we        = 1'b0;
    pc_we         = 1'b0;
    halted        = 1'b0;
    set_err       = 1'b0;
    retire        = 1'b0;
    case (cur_state)
      S_IF_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          nxt_state = S_IF_WAIT;
        end else if (tmo_hit) begin
          nxt_state = S_HALTED;
          set_err   = 1'b1;
        end
      end
      S_IF_WAIT: begin
        if (ifu_resp_valid) begin
          ir_we     = 1'b1;
          nxt_state = S_EX;
        end else if (tmo_hit) begin
          nxt_state = S_HALTED;
          set_err   = 1'b1;
        end
      end
      S_EX: begin
        if (dec_halt)
          nxt_state = S_HALTED;
        else if (dec_load || dec_store)
          nxt_state = S_LS_REQ;
        else
          nxt_state = S_WB;
      end
      S_LS_REQ: begin
        lsu_req_valid = 1'b1;
        lsu_wr        = dec_store;
        if (lsu_req_ready) begin
          nxt_state = S_LS_WAIT;
        end else if (tmo_hit) begin
          nxt_state = S_HALTED;
          set_err   = 1'b1;
        end
      end
      S_LS_WAIT: begin
        if (lsu_resp_valid) begin
          nxt_state = S_WB;
        end else if (tmo_hit) begin
          nxt_state = S_HALTED;
          set_err   = 1'b1;
        end
      end
      S_WB: begin
        pc_we     = 1'b1;
        reg_we    = dec_wen && !dec_store;
        retire    = 1'b1;
        nxt_state = S_IF_REQ;
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b1;
      end
    endcase
  end

  assign bus_err = err_q || (cur_state == S_BAD);
  assign state   = cur_state;
  assign instret = instret_q;

endmodule
